up_mem_master: RTL and testbench
================================

# up_mem_master

Bus-master front end for the 8-bit processor's 256-byte data memory port. It accepts burst read/write commands over a valid/ready command channel and streams write bytes in and read bytes out, each with valid/ready. It drives the memory's address/data/write-enable pins, which have a combinational read and a clocked write. It sits between the core (or a loader/debug port) and the memory.

## Interface
- LEN_W, 8: width of `cmd_len`. Burst beats = `cmd_len`+1, so 1..2^LEN_W beats.
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with `cmd_valid`
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  8  start address
- cmd_len  in  LEN_W  beats minus one
- wr_data  in  8  write stream byte
- wr_valid  in  1  write byte offered
- wr_ready  out  1  write byte consumed when high with `wr_valid`
- rd_data  out  8  read stream byte (registered)
- rd_valid  out  1  read byte available
- rd_ready  in  1  downstream takes `rd_data`
- mem_address  out  8  memory address (registered)
- mem_in  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_out  in  8  memory read data, combinational from `mem_address`
- mem_re  in  1  memory available; no access is made while low
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on burst completion

## Operation
- States: IDLE, WR, RD.
- IDLE: `cmd_ready` = !rd_valid. On handshake, latch `cmd_addr` into `mem_address` and `cmd_len` into the remaining counter. Go to WR or RD according to `cmd_write`.
- WR:
  - `wr_ready` = mem_re.
  - `mem_we` = wr_valid & mem_re & !rst; `mem_in` = wr_data (combinational).
  - On each accepted beat: `mem_address`+1 (wraps 0xFF->0x00) and the counter decrements.
  - When the beat with counter==0 is accepted: go to IDLE and pulse `done`.
- RD:
  - A beat issues when mem_re & (!rd_valid | rd_ready).
  - On issue: `rd_data` <= mem_out, `rd_valid` <= 1, address +1 with wrap, counter decrements.
  - When rd_ready & rd_valid and no beat issues, `rd_valid` <= 0.
  - The last beat issued returns the FSM to IDLE and pulses `done`. `rd_valid` for that beat persists until consumed, and it blocks `cmd_ready`.
- `mem_we` is 0 outside WR. `wr_ready` is 0 outside WR.
- Bursts longer than 256 beats (LEN_W>8) wrap the address repeatedly.

## Timing
- All outputs are 0 while `rst` is high. This includes `cmd_ready`, `mem_we` and `done`. Registers reset to 0 and state resets to IDLE. `cmd_ready`=1 in the first cycle after release.
- `rst` mid-burst: return to IDLE at the next edge and abandon the remaining beats. `rd_valid` clears. No write occurs in the reset cycle.
- Write: cmd handshake in cycle c0. The first write can fire in c1. Throughput is 1 byte/cycle with `wr_valid`=`mem_re`=1. An N-beat burst completes in cycles c1..cN, and `done` is high in cycle cN+1.
- Read: cmd handshake in c0. `mem_address`=cmd_addr in c1. In c2, `rd_valid`=1 and `rd_data`=mem[cmd_addr]. Throughput is 1 byte/cycle with `rd_ready` held high.
- Backpressure: while rd_valid & !rd_ready, `rd_data` and `mem_address` hold. `mem_re`=0 stalls both directions without losing beats.
- A new command is accepted no earlier than the cycle after `done`.

## Configuration
- `UP_MEM_MASTER_FILL_EN` defined:
  - Adds ports `cmd_fill` (in 1) and `cmd_data` (in 8), both latched at the command handshake.
  - A write command with `cmd_fill`=1 writes the latched `cmd_data` on every beat, one beat per cycle while `mem_re`. `wr_ready` is held 0 for that burst.
  - `cmd_fill` is ignored on reads.
- Not defined: the ports are absent and all write data comes from the write stream.

## Test plan
- Reset: rst high for 2 cycles while `cmd_valid`=1 -> all outputs 0 and no handshake. The cycle after release, `cmd_ready`=1 and `busy`=0.
- Read burst: memory preloaded mem[0..2]=75,5C,69; cmd read addr=0 len=2, rd_ready=1 -> rd_data 75,5C,69 in consecutive cycles starting c2. `done` pulses once, and `cmd_ready` returns after the last byte is taken.
- Write wrap: cmd write addr=FE len=2, wr_data AA,BB,CC with no gaps -> mem[FE]=AA, mem[FF]=BB, mem[00]=CC. `mem_we` is high for exactly 3 cycles.
- Stalls: read addr=10 len=3 with rd_ready toggling 1,0,0,1,... and mem_re low for one cycle -> exactly 4 bytes mem[10..13] in order, with no duplicates or drops.
- Reset mid-burst: write len=7, rst asserted after 3 beats -> only mem[addr..addr+2] are changed, `mem_we`=0 in the reset cycle, and the FSM is IDLE afterwards.
- With `UP_MEM_MASTER_FILL_EN`: fill addr=40 len=3 data=5A -> mem[40..43]=5A, `wr_ready` stays 0, and `done` is high in the cycle after the 4th write.

Source files
------------

// File: rtl/up_mem_master.sv
// Burst bus master for the 256-byte data memory: valid/ready command channel plus write/read byte streams.
// Optional constant-fill write bursts are compiled in with `define UP_MEM_MASTER_FILL_EN.
module up_mem_master #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [7:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
`ifdef UP_MEM_MASTER_FILL_EN
    input  logic             cmd_fill,
    input  logic [7:0]       cmd_data,
`endif
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       mem_address,
    output logic [7:0]       mem_in,
    output logic             mem_we,
    input  logic [7:0]       mem_out,
    input  logic             mem_re,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;
    logic              done_q;

    logic              cmd_ok;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_issue;
    logic              beat;
    logic              last_beat;
    logic              wr_ready_c;
    logic              mem_we_c;
    logic [7:0]        mem_in_c;

`ifdef UP_MEM_MASTER_FILL_EN
    logic              fill_q;
    logic [7:0]        fill_data_q;

    // Fill only applies to write bursts, so the read case latches it as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= 1'b0;
            fill_data_q <= 8'h00;
        end else if (cmd_fire) begin
            fill_q      <= cmd_write & cmd_fill;
            fill_data_q <= cmd_data;
        end
    end
`else
    logic              fill_q;
    logic [7:0]        fill_data_q;

    assign fill_q      = 1'b0;
    assign fill_data_q = 8'h00;
`endif

    assign last_beat = (remain_q == '0);
    assign beat      = wr_fire | rd_issue;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cmd_ok     = 1'b0;
        cmd_fire   = 1'b0;
        wr_fire    = 1'b0;
        rd_issue   = 1'b0;
        wr_ready_c = 1'b0;
        mem_we_c   = 1'b0;
        mem_in_c   = 8'h00;
        unique case (state_q)
            IDLE: begin
                // The done cycle also blocks so a new command lands strictly after it.
                cmd_ok   = !rd_valid_q && !done_q;
                cmd_fire = cmd_valid && cmd_ok;
                if (cmd_fire) state_d = cmd_write ? WR : RD;
            end
            WR: begin
                wr_ready_c = mem_re && !fill_q;
                mem_in_c   = fill_q ? fill_data_q : wr_data;
                wr_fire    = mem_re && (fill_q || wr_valid);
                mem_we_c   = wr_fire;
                if (wr_fire && last_beat) state_d = IDLE;
            end
            RD: begin
                rd_issue = mem_re && (!rd_valid_q || rd_ready);
                if (rd_issue && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            remain_q   <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= beat && last_beat;
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_len;
            end else if (beat) begin
                addr_q   <= addr_q + 8'd1;
                remain_q <= remain_q - 1'b1;
            end
            if (rd_issue) begin
                rd_data_q  <= mem_out;
                rd_valid_q <= 1'b1;
            end else if (rd_valid_q && rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: outputs are masked by rst so they read 0 during the reset cycle itself, not only after the edge.
    assign cmd_ready   = !rst && cmd_ok;
    assign wr_ready    = !rst && wr_ready_c;
    assign mem_we      = !rst && mem_we_c;
    assign mem_in      = rst ? 8'h00 : mem_in_c;
    assign mem_address = rst ? 8'h00 : addr_q;
    assign rd_data     = rst ? 8'h00 : rd_data_q;
    assign rd_valid    = !rst && rd_valid_q;
    assign busy        = !rst && (state_q != IDLE);
    assign done        = !rst && done_q;

endmodule

// File: tb/tb_up_mem_master.sv
// Self-checking bench for up_mem_master: random bursts against a byte-array memory model and scoreboard.
// Fill-mode checks are compiled in when UP_MEM_MASTER_FILL_EN is defined.
module tb_up_mem_master;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [7:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
`ifdef UP_MEM_MASTER_FILL_EN
    logic             cmd_fill;
    logic [7:0]       cmd_data;
`endif
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [7:0]       mem_address;
    logic [7:0]       mem_in;
    logic             mem_we;
    logic [7:0]       mem_out;
    logic             mem_re;
    logic             busy;
    logic             done;

    up_mem_master #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef UP_MEM_MASTER_FILL_EN
        .cmd_fill(cmd_fill), .cmd_data(cmd_data),
`endif
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we),
        .mem_out(mem_out), .mem_re(mem_re),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT (combinational read, clocked write) plus a preload port.
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_in;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end
    assign mem_out = mem[mem_address];

    // Expected memory image and stream buffers.
    logic [7:0] ref_mem [256];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    int n_vec, n_err;
    bit r_ok, r_rdy_after, r_rdy_at_done;
    int r_first, r_last, r_done_cyc, r_we, r_done_cnt, r_extra;
    int first_diff;

    function automatic int mem_diffs();
        int d = 0;
        first_diff = -1;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) begin
                d++;
                if (first_diff < 0) first_diff = i;
            end
        return d;
    endfunction

    task automatic preload();
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = 8'($urandom);
            if (i == 0) v = 8'h75;
            if (i == 1) v = 8'h5C;
            if (i == 2) v = 8'h69;
            pre_we = 1'b1; pre_addr = 8'(i); pre_data = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Offers a command until accepted; starts and ends on a falling edge.
    task automatic send_cmd(input bit wr, input logic [7:0] addr, input int len, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LEN_W'(len);
        for (int c = 0; c < 64; c++) begin
            #1;
            if (cmd_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    // Write burst: a beat happens whenever mem_re and (fill or wr_valid); ref_mem follows each beat.
    task automatic do_write(input logic [7:0] addr, input int len, input int gap_pct,
                            input int stall_pct, input bit fill, input logic [7:0] fill_data);
        int idx;
        bit beat;
        r_we = 0; r_done_cnt = 0; r_last = -1; r_done_cyc = -1;
        r_rdy_after = 1'b0; r_rdy_at_done = 1'b1;
`ifdef UP_MEM_MASTER_FILL_EN
        cmd_fill = fill; cmd_data = fill_data;
`endif
        send_cmd(1'b1, addr, len, r_ok);
        if (!r_ok) return;
        idx = 0;
        for (int c = 1; c < 40 * (len + 1) + 40 && idx <= len; c++) begin
            wr_valid = ($urandom_range(99) >= gap_pct);
            if (fill) wr_data = 8'($urandom);
            else wr_data = tx_q[idx];
            mem_re = ($urandom_range(99) >= stall_pct);
            #1;
            beat = mem_re && (fill || wr_valid);
            n_vec++;
            if (wr_ready !== (mem_re && !fill) || mem_we !== beat) begin
                n_err++;
                $display("FAIL wr_strobe cyc=%0d: wr_ready=%b mem_we=%b, expected %b %b",
                         c, wr_ready, mem_we, mem_re && !fill, beat);
            end
            if (mem_we === 1'b1) r_we++;
            if (done === 1'b1) begin r_done_cnt++; r_done_cyc = c; end
            if (beat) begin
                ref_mem[8'(int'(addr) + idx)] = fill ? fill_data : tx_q[idx];
                idx++;
                r_last = c;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0; mem_re = 1'b1;
        if (idx <= len) begin r_ok = 1'b0; return; end
        for (int k = 0; k < 3; k++) begin
            #1;
            if (mem_we === 1'b1) r_we++;
            if (done === 1'b1) begin r_done_cnt++; r_done_cyc = r_last + 1 + k; end
            if (k == 0) r_rdy_at_done = cmd_ready;
            if (k == 1) r_rdy_after = cmd_ready;
            @(negedge clk);
        end
    endtask

    // Read burst: collects consumed bytes into rx_q and checks that stalled outputs hold.
    task automatic do_read(input logic [7:0] addr, input int len, input int rdy_mode,
                           input int stall_pct, input int stall_at);
        bit prev_hold;
        logic [7:0] prev_data, prev_addr;
        rx_q.delete();
        r_first = -1; r_last = -1; r_done_cnt = 0; r_extra = 0; r_rdy_after = 1'b0;
        rd_ready = 1'b0;
        send_cmd(1'b0, addr, len, r_ok);
        if (!r_ok) return;
        r_ok = 1'b0;
        prev_hold = 1'b0; prev_data = 8'h00; prev_addr = 8'h00;
        for (int c = 1; c < 40 * (len + 1) + 40; c++) begin
            case (rdy_mode)
                0: rd_ready = 1'b1;
                1: rd_ready = (c % 3 == 2);
                default: rd_ready = 1'($urandom);
            endcase
            mem_re = (c != stall_at) && ($urandom_range(99) >= stall_pct);
            #1;
            if (prev_hold) begin
                n_vec++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data || mem_address !== prev_addr) begin
                    n_err++;
                    $display("FAIL rd_hold cyc=%0d: valid=%b data=%h addr=%h, expected 1 %h %h",
                             c, rd_valid, rd_data, mem_address, prev_data, prev_addr);
                end
            end
            if (done === 1'b1) r_done_cnt++;
            if (rd_valid === 1'b1 && rd_ready) begin
                rx_q.push_back(rd_data);
                if (r_first < 0) r_first = c;
                r_last = c;
            end
            prev_hold = (rd_valid === 1'b1) && !rd_ready;
            prev_data = rd_data; prev_addr = mem_address;
            @(negedge clk);
            if (rx_q.size() == len + 1) begin r_ok = 1'b1; break; end
        end
        rd_ready = 1'b1; mem_re = 1'b1;
        if (!r_ok) return;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (rd_valid === 1'b1) r_extra++;
            if (done === 1'b1) r_done_cnt++;
            if (k == 0) r_rdy_after = cmd_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33; cmd_len = 8'd5;
        wr_valid = 1'b1; rd_ready = 1'b1; mem_re = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if ({cmd_ready, wr_ready, rd_valid, mem_we, busy, done} !== 6'b0 ||
                mem_address !== 8'h00 || rd_data !== 8'h00 || mem_in !== 8'h00) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d: rdy/wrdy/rv/we/busy/done=%b%b%b%b%b%b addr=%h rd=%h in=%h, expected all 0",
                         c, cmd_ready, wr_ready, rd_valid, mem_we, busy, done, mem_address, rd_data, mem_in);
            end
            @(negedge clk);
        end
        rst = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_read_burst();
        logic [7:0] exp [3];
        exp[0] = 8'h75; exp[1] = 8'h5C; exp[2] = 8'h69;
        do_read(8'h00, 2, 0, 0, -1);
        n_vec++;
        if (!r_ok) begin n_err++; $display("FAIL read_timeout: got %0d bytes, expected 3", rx_q.size()); return; end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rx_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL read_data[%0d]: got %h, expected %h", i, rx_q[i], exp[i]);
            end
        end
        n_vec++;
        if (r_first !== 2 || r_last !== 4) begin
            n_err++;
            $display("FAIL read_timing: first=%0d last=%0d, expected 2 4", r_first, r_last);
        end
        n_vec++;
        if (r_done_cnt !== 1 || r_extra !== 0 || r_rdy_after !== 1'b1) begin
            n_err++;
            $display("FAIL read_end: done_cnt=%0d extra=%0d cmd_ready=%b, expected 1 0 1",
                     r_done_cnt, r_extra, r_rdy_after);
        end
    endtask

    task automatic test_write_wrap();
        tx_q.delete();
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
        do_write(8'hFE, 2, 0, 0, 1'b0, 8'h00);
        n_vec++;
        if (!r_ok) begin n_err++; $display("FAIL wrap_timeout: burst did not complete, expected 3 beats"); return; end
        n_vec++;
        if (mem[8'hFE] !== 8'hAA || mem[8'hFF] !== 8'hBB || mem[8'h00] !== 8'hCC) begin
            n_err++;
            $display("FAIL wrap_mem: FE/FF/00=%h %h %h, expected aa bb cc", mem[8'hFE], mem[8'hFF], mem[8'h00]);
        end
        n_vec++;
        if (r_we !== 3 || r_last !== 3) begin
            n_err++;
            $display("FAIL wrap_we: we_cycles=%0d last=%0d, expected 3 3", r_we, r_last);
        end
        n_vec++;
        if (r_done_cnt !== 1 || r_done_cyc !== 4 || r_rdy_at_done !== 1'b0 || r_rdy_after !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_done: cnt=%0d cyc=%0d rdy_at_done=%b rdy_after=%b, expected 1 4 0 1",
                     r_done_cnt, r_done_cyc, r_rdy_at_done, r_rdy_after);
        end
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL wrap_image: first bad addr %0d got %h, expected %h",
                     first_diff, mem[first_diff], ref_mem[first_diff]);
        end
    endtask

    task automatic test_stalls();
        int bad = 0;
        do_read(8'h10, 3, 1, 0, 3);
        n_vec++;
        if (!r_ok || rx_q.size() !== 4) begin
            n_err++;
            $display("FAIL stall_count: got %0d bytes, expected 4", rx_q.size());
            return;
        end
        for (int i = 0; i < 4; i++)
            if (rx_q[i] !== ref_mem[8'h10 + i]) bad++;
        n_vec++;
        if (bad !== 0 || r_extra !== 0 || r_done_cnt !== 1) begin
            n_err++;
            $display("FAIL stall_data: bad=%0d extra=%0d done_cnt=%0d, expected 0 0 1", bad, r_extra, r_done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bit ok;
        send_cmd(1'b1, 8'h80, 7, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL midrst_cmd: not accepted, expected handshake"); return; end
        for (int c = 0; c < 3; c++) begin
            d = 8'($urandom);
            wr_valid = 1'b1; wr_data = d; mem_re = 1'b1;
            ref_mem[8'h80 + c] = d;
            @(negedge clk);
        end
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h11; mem_re = 1'b1;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_cycle: mem_we=%b wr_ready=%b done=%b, expected 0 0 0", mem_we, wr_ready, done);
        end
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_idle: busy=%b cmd_ready=%b, expected 0 1", busy, cmd_ready);
        end
        @(negedge clk);
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL midrst_image: first bad addr %0d got %h, expected %h",
                     first_diff, mem[first_diff], ref_mem[first_diff]);
        end
    endtask

`ifdef UP_MEM_MASTER_FILL_EN
    task automatic test_fill();
        do_write(8'h40, 3, 30, 0, 1'b1, 8'h5A);
        n_vec++;
        if (!r_ok) begin n_err++; $display("FAIL fill_timeout: burst did not complete, expected 4 beats"); return; end
        n_vec++;
        if (mem[8'h40] !== 8'h5A || mem[8'h41] !== 8'h5A || mem[8'h42] !== 8'h5A || mem[8'h43] !== 8'h5A) begin
            n_err++;
            $display("FAIL fill_mem: 40..43=%h %h %h %h, expected 5a", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
        end
        n_vec++;
        if (r_we !== 4 || r_last !== 4 || r_done_cyc !== 5 || r_done_cnt !== 1) begin
            n_err++;
            $display("FAIL fill_timing: we=%0d last=%0d done_cyc=%0d done_cnt=%0d, expected 4 4 5 1",
                     r_we, r_last, r_done_cyc, r_done_cnt);
        end
        cmd_fill = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] a;
        int l, bad;
        bit w;
        for (int t = 0; t < 30; t++) begin
            w = 1'($urandom);
            a = 8'($urandom);
            l = (t == 7) ? 255 : int'($urandom_range(0, 20));
            if (w) begin
                tx_q.delete();
                for (int i = 0; i <= l; i++) tx_q.push_back(8'($urandom));
                do_write(a, l, int'($urandom_range(0, 40)), int'($urandom_range(0, 30)), 1'b0, 8'h00);
                n_vec++;
                if (!r_ok || r_we !== l + 1 || r_done_cnt !== 1 || mem_diffs() !== 0) begin
                    n_err++;
                    $display("FAIL rand_write t=%0d addr=%h len=%0d: ok=%b we=%0d done=%0d bad_addr=%0d, expected 1 %0d 1 -1",
                             t, a, l, r_ok, r_we, r_done_cnt, first_diff, l + 1);
                end
            end else begin
                do_read(a, l, int'($urandom_range(0, 2)), int'($urandom_range(0, 30)), -1);
                bad = 0;
                if (r_ok)
                    for (int i = 0; i <= l; i++)
                        if (rx_q[i] !== ref_mem[8'(int'(a) + i)]) bad++;
                n_vec++;
                if (!r_ok || bad !== 0 || r_extra !== 0 || r_done_cnt !== 1 || r_rdy_after !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_read t=%0d addr=%h len=%0d: ok=%b bad=%0d extra=%0d done=%0d rdy=%b, expected 1 0 0 1 1",
                             t, a, l, r_ok, bad, r_extra, r_done_cnt, r_rdy_after);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = '0;
        wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0; mem_re = 1'b1;
        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
`ifdef UP_MEM_MASTER_FILL_EN
        cmd_fill = 1'b0; cmd_data = 8'h00;
`endif
        preload();
        test_reset();
        test_read_burst();
        test_write_wrap();
        test_stalls();
        test_reset_mid();
`ifdef UP_MEM_MASTER_FILL_EN
        test_fill();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
